// File: rtl/potato1_pkg.sv
// Shared Potato-1 definitions: Command bit positions and the I/O handshake FSM states.
package potato1_pkg;

    localparam int CMD_PC_INC = 0;
    localparam int CMD_PC_DEC = 1;
    localparam int CMD_X_INC  = 2;
    localparam int CMD_X_DEC  = 3;
    localparam int CMD_A_INC  = 4;
    localparam int CMD_A_DEC  = 5;
    localparam int CMD_PUT    = 6;
    localparam int CMD_GET    = 7;

    typedef enum logic [1:0] {
        IO_IDLE     = 2'd0,
        IO_PUT_WAIT = 2'd1,
        IO_GET_WAIT = 2'd2,
        IO_DONE     = 2'd3
    } io_state_e;

endpackage

// File: rtl/potato1_io_port.sv
// Potato-1 byte I/O engine: PUT/GET valid-ready handshakes, IOReady strobe and
// the tape write request that a completed GET produces.
module potato1_io_port
    import potato1_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  put,
    input  logic                  get,
    input  logic [DATA_WIDTH-1:0] cell_data,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    input  logic [DATA_WIDTH-1:0] In_Data,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    output logic                  IOReady,
    output logic                  tape_we,
    output logic [DATA_WIDTH-1:0] tape_wdata
);

    io_state_e             state_r;
    io_state_e             state_nxt_s;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_valid_r;
    logic                  in_ready_r;
    logic                  io_ready_r;

    // FSM state register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IO_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state; PUT takes priority over GET, and new requests are only heard in IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IO_IDLE: begin
                if (put) begin
                    state_nxt_s = IO_PUT_WAIT;
                end else if (get) begin
                    state_nxt_s = IO_GET_WAIT;
                end else begin
                    state_nxt_s = IO_IDLE;
                end
            end
            IO_PUT_WAIT: begin
                if (Out_Ready) begin
                    state_nxt_s = IO_DONE;
                end else begin
                    state_nxt_s = IO_PUT_WAIT;
                end
            end
            IO_GET_WAIT: begin
                if (In_Valid) begin
                    state_nxt_s = IO_DONE;
                end else begin
                    state_nxt_s = IO_GET_WAIT;
                end
            end
            IO_DONE: state_nxt_s = IO_IDLE;
            default: state_nxt_s = IO_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the state being entered
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            io_ready_r  <= 1'b0;
        end else begin
            if ((state_r == IO_IDLE) && put) begin
                out_data_r <= cell_data;
            end
            out_valid_r <= (state_nxt_s == IO_PUT_WAIT);
            in_ready_r  <= (state_nxt_s == IO_GET_WAIT);
            io_ready_r  <= (state_nxt_s == IO_DONE);
        end
    end

    assign Out_Data   = out_data_r;
    assign Out_Valid  = out_valid_r;
    assign In_Ready   = in_ready_r;
    assign IOReady    = io_ready_r;
    assign tape_we    = (state_r == IO_GET_WAIT) && In_Valid;
    assign tape_wdata = In_Data;

endmodule

// File: rtl/potato1_datapath.sv
// Potato-1 execution datapath: PC, tape pointer X, tape cells and byte I/O.
// Build option POTATO1_TAPE_RESET_EN: clear every tape cell on Reset_n.
module potato1_datapath
    import potato1_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [7:0]            Command,
    output logic [PC_WIDTH-1:0]   Prog_Addr,
    input  logic [3:0]            Prog_Data,
    output logic [3:0]            Instruction,
    output logic                  State,
    output logic                  IOReady,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    input  logic [DATA_WIDTH-1:0] In_Data,
    input  logic                  In_Valid,
    output logic                  In_Ready
);

    localparam int CELLS = 2 ** ADDR_WIDTH;

    logic [PC_WIDTH-1:0]   pc_r;
    logic [PC_WIDTH-1:0]   pc_nxt_s;
    logic [ADDR_WIDTH-1:0] x_r;
    logic [ADDR_WIDTH-1:0] x_nxt_s;
    logic [DATA_WIDTH-1:0] tape_r [CELLS];
    logic [DATA_WIDTH-1:0] cell_s;
    logic                  tape_we_s;
    logic [DATA_WIDTH-1:0] tape_wdata_s;
    logic                  io_we_s;
    logic [DATA_WIDTH-1:0] io_wdata_s;

    assign cell_s = tape_r[x_r];

    // PC and X next values; opposing bits cancel
    always_comb begin
        pc_nxt_s = pc_r;
        x_nxt_s  = x_r;
        case ({Command[CMD_PC_DEC], Command[CMD_PC_INC]})
            2'b01:   pc_nxt_s = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            2'b10:   pc_nxt_s = pc_r - {{(PC_WIDTH-1){1'b0}}, 1'b1};
            default: pc_nxt_s = pc_r;
        endcase
        case ({Command[CMD_X_DEC], Command[CMD_X_INC]})
            2'b01:   x_nxt_s = x_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            2'b10:   x_nxt_s = x_r - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            default: x_nxt_s = x_r;
        endcase
    end

    // Single tape write port at the pre-update X; a completing GET overrides A_INC/A_DEC
    always_comb begin
        tape_we_s    = 1'b0;
        tape_wdata_s = cell_s;
        if (io_we_s) begin
            tape_we_s    = 1'b1;
            tape_wdata_s = io_wdata_s;
        end else begin
            case ({Command[CMD_A_DEC], Command[CMD_A_INC]})
                2'b01: begin
                    tape_we_s    = 1'b1;
                    tape_wdata_s = cell_s + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                end
                2'b10: begin
                    tape_we_s    = 1'b1;
                    tape_wdata_s = cell_s - {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                end
                default: begin
                    tape_we_s    = 1'b0;
                    tape_wdata_s = cell_s;
                end
            endcase
        end
    end

    // PC and tape pointer registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_r <= {PC_WIDTH{1'b0}};
            x_r  <= {ADDR_WIDTH{1'b0}};
        end else begin
            pc_r <= pc_nxt_s;
            x_r  <= x_nxt_s;
        end
    end

`ifdef POTATO1_TAPE_RESET_EN
    // Tape storage, cleared by reset
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < CELLS; i++) begin
                tape_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (tape_we_s) begin
            tape_r[x_r] <= tape_wdata_s;
        end
    end
`else
    // Tape storage without reset so it can map onto RAM
    always_ff @(posedge Clock) begin
        if (tape_we_s) begin
            tape_r[x_r] <= tape_wdata_s;
        end
    end
`endif

    potato1_io_port #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_io_port (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .put        (Command[CMD_PUT]),
        .get        (Command[CMD_GET]),
        .cell_data  (cell_s),
        .Out_Data   (Out_Data),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .In_Data    (In_Data),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .IOReady    (IOReady),
        .tape_we    (io_we_s),
        .tape_wdata (io_wdata_s)
    );

    assign Prog_Addr   = pc_r;
    assign Instruction = Prog_Data;
    assign State       = (cell_s == {DATA_WIDTH{1'b0}});

endmodule

// File: tb/tb_potato1_datapath.sv
// Directed self-checking bench for potato1_datapath; Command is driven on negedge
// and outputs are sampled on negedge, half a cycle away from the sampling posedge.
module tb_potato1_datapath;

    logic       Clock;
    logic       Reset_n;
    logic [7:0] Command;
    logic [7:0] Prog_Addr;
    logic [3:0] Prog_Data;
    logic [3:0] Instruction;
    logic       State;
    logic       IOReady;
    logic [7:0] Out_Data;
    logic       Out_Valid;
    logic       Out_Ready;
    logic [7:0] In_Data;
    logic       In_Valid;
    logic       In_Ready;

    int         check_cnt;
    int         error_cnt;

    potato1_datapath dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Command     (Command),
        .Prog_Addr   (Prog_Addr),
        .Prog_Data   (Prog_Data),
        .Instruction (Instruction),
        .State       (State),
        .IOReady     (IOReady),
        .Out_Data    (Out_Data),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .In_Data     (In_Data),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Program memory model: nibble derived from the address
    assign Prog_Data = Prog_Addr[3:0] ^ 4'hA;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one command for exactly one posedge, returning at the following negedge
    task automatic step(input logic [7:0] cmd);
        @(negedge Clock);
        Command = cmd;
        @(negedge Clock);
        Command = 8'h00;
    endtask

    task automatic do_get(input logic [7:0] data, input int delay, input logic [7:0] cmd_at_valid);
        step(8'h80);
        check("get_in_ready", 32'(In_Ready), 32'd1);
        for (int i = 0; i < delay; i++) begin
            @(negedge Clock);
            check("get_wait_in_ready", 32'(In_Ready), 32'd1);
            check("get_wait_no_ioready", 32'(IOReady), 32'd0);
        end
        In_Valid = 1'b1;
        In_Data  = data;
        Command  = cmd_at_valid;
        @(negedge Clock);
        In_Valid = 1'b0;
        Command  = 8'h00;
        check("get_in_ready_drop", 32'(In_Ready), 32'd0);
        check("get_ioready_pulse", 32'(IOReady), 32'd1);
        @(negedge Clock);
        check("get_ioready_end", 32'(IOReady), 32'd0);
    endtask

    task automatic do_put(input logic [7:0] cmd, input int delay, input logic [7:0] exp);
        step(cmd);
        check("put_out_valid", 32'(Out_Valid), 32'd1);
        check("put_out_data", 32'(Out_Data), 32'(exp));
        check("put_no_in_ready", 32'(In_Ready), 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(negedge Clock);
            check("put_wait_valid", 32'(Out_Valid), 32'd1);
            check("put_wait_data", 32'(Out_Data), 32'(exp));
            check("put_wait_no_ioready", 32'(IOReady), 32'd0);
        end
        Out_Ready = 1'b1;
        @(negedge Clock);
        Out_Ready = 1'b0;
        check("put_valid_drop", 32'(Out_Valid), 32'd0);
        check("put_ioready_pulse", 32'(IOReady), 32'd1);
        @(negedge Clock);
        check("put_ioready_end", 32'(IOReady), 32'd0);
    endtask

    initial begin
        logic [7:0] pc_e;
        check_cnt = 0;
        error_cnt = 0;
        Reset_n   = 1'b0;
        Command   = 8'h00;
        Out_Ready = 1'b0;
        In_Data   = 8'h00;
        In_Valid  = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_pc", 32'(Prog_Addr), 32'd0);
        check("rst_out_valid", 32'(Out_Valid), 32'd0);
        check("rst_out_data", 32'(Out_Data), 32'd0);
        check("rst_in_ready", 32'(In_Ready), 32'd0);
        check("rst_ioready", 32'(IOReady), 32'd0);
`ifdef POTATO1_TAPE_RESET_EN
        check("rst_state", 32'(State), 32'd1);
`endif
        Reset_n = 1'b1;

        // Program counter
        repeat (3) step(8'h01);
        pc_e = 8'd3;
        check("pc_inc3", 32'(Prog_Addr), 32'(pc_e));
        check("instr_3", 32'(Instruction), 32'(pc_e[3:0] ^ 4'hA));
        step(8'h02);
        pc_e = 8'd2;
        check("pc_dec", 32'(Prog_Addr), 32'(pc_e));
        check("instr_2", 32'(Instruction), 32'(pc_e[3:0] ^ 4'hA));
        repeat (3) step(8'h02);
        check("pc_dec_wrap", 32'(Prog_Addr), 32'd255);
        step(8'h01);
        check("pc_inc_wrap", 32'(Prog_Addr), 32'd0);
        step(8'h03);
        check("pc_both_hold", 32'(Prog_Addr), 32'd0);

        // Preload tape[0] with a GET and send it back with a slow consumer
        do_get(8'h41, 0, 8'h00);
        check("state_cell41", 32'(State), 32'd0);
        do_put(8'h40, 5, 8'h41);

        // X wraps to 15; GET with a late In_Valid writes zero
        step(8'h08);
        do_get(8'h00, 2, 8'h00);
        check("state_get_zero", 32'(State), 32'd1);
        step(8'h20);
        check("state_after_adec", 32'(State), 32'd0);
        do_put(8'h40, 0, 8'hFF);
        step(8'h10);
        check("state_after_ainc", 32'(State), 32'd1);
        step(8'h30);
        check("state_a_both_hold", 32'(State), 32'd1);

        // A_INC lands on the old X while X moves to 0 in the same cycle
        step(8'h14);
        check("state_x_moved", 32'(State), 32'd0);
        do_put(8'h40, 0, 8'h41);
        step(8'h08);
        check("state_x15_one", 32'(State), 32'd0);
        do_put(8'h40, 0, 8'h01);
        step(8'h0C);
        do_put(8'h40, 0, 8'h01);

        // GET completion beats a concurrent A_INC on the same cell
        do_get(8'h7E, 0, 8'h10);
        do_put(8'h40, 0, 8'h7E);

        // PUT and GET together: PUT only, tape untouched
        do_put(8'hC0, 1, 8'h7E);
        do_put(8'h40, 0, 8'h7E);

        // Move X back to 0, advance PC, then reset in the middle of PUT_WAIT
        step(8'h04);
        step(8'h01);
        check("pc_before_rst", 32'(Prog_Addr), 32'd1);
        step(8'h40);
        check("midrst_valid_before", 32'(Out_Valid), 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("midrst_valid_drop", 32'(Out_Valid), 32'd0);
        check("midrst_pc", 32'(Prog_Addr), 32'd0);
        check("midrst_ioready", 32'(IOReady), 32'd0);
        Out_Ready = 1'b1;
        @(negedge Clock);
        Reset_n = 1'b1;
        repeat (2) begin
            @(negedge Clock);
            check("postrst_no_ioready", 32'(IOReady), 32'd0);
            check("postrst_no_valid", 32'(Out_Valid), 32'd0);
        end
        Out_Ready = 1'b0;
`ifdef POTATO1_TAPE_RESET_EN
        check("postrst_state", 32'(State), 32'd1);
        do_put(8'h40, 0, 8'h00);
`else
        do_put(8'h40, 0, 8'h41);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
